scan_dump_sequencer: RTL and testbench

Sequencer that runs a CSoC scan-dump procedure: holds the SoC in reset, clocks it functionally for a programmed number of ticks, then switches to scan mode and shifts the whole scan chain out one bit per CSoC clock. Each bit goes to the board UART transmitter as ASCII '0'/'1', with line breaks. It sits between the UART command/TX path and the CSoC test pins, and is the only driver of csoc_clk, csoc_rstn, csoc_test_se and csoc_test_tm.

---
 rtl/scan_dump_sequencer_if.sv | 27 ++
 rtl/scan_dump_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_scan_dump_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/scan_dump_sequencer_if.sv
// ============================================================================
// Module      : scan_dump_sequencer_if
// Description : Byte-strobe handshake between the scan-dump sequencer and the
//               board UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_dump_sequencer_if;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_i;

    modport master (
        output tx_start_o,
        output tx_data_o,
        input  tx_ready_i
    );

    modport slave (
        input  tx_start_o,
        input  tx_data_o,
        output tx_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/scan_dump_sequencer.sv
// ============================================================================
// Module      : scan_dump_sequencer
// Description : Resets and runs the CSoC, then shifts its scan chain out as
//               ASCII '0'/'1' characters over the UART, COLS per line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_dump_sequencer #(
    parameter int CHAIN_LEN  = 1919,
    parameter int RUN_TICKS  = 10,
    parameter int COLS       = 8,
    parameter int RST_CYCLES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start_i,
    output      logic                  busy_o,
    output      logic                  done_o,
    scan_dump_sequencer_if.master      tx,
    output      logic                  csoc_clk,
    output      logic                  csoc_rstn,
    output      logic                  csoc_test_se,
    output      logic                  csoc_test_tm,
    input  wire logic                  csoc_scan_i,
    output      logic                  csoc_scan_o
);

    localparam int c_RST_W = $clog2(RST_CYCLES + 1);
    localparam int c_RUN_W = (RUN_TICKS > 0) ? $clog2(RUN_TICKS + 1) : 1;
    localparam int c_BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int c_COL_W = $clog2(COLS + 1);

    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'((RUN_TICKS > 0) ? RUN_TICKS - 1 : 0);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(CHAIN_LEN - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_SOC_RST   = 4'd1;
    localparam logic [3:0] c_RUN_HI    = 4'd2;
    localparam logic [3:0] c_RUN_LO    = 4'd3;
    localparam logic [3:0] c_SETUP     = 4'd4;
    localparam logic [3:0] c_SH_TX     = 4'd5;
    localparam logic [3:0] c_SH_WAIT   = 4'd6;
    localparam logic [3:0] c_SH_NL     = 4'd7;
    localparam logic [3:0] c_SH_NLWAIT = 4'd8;
    localparam logic [3:0] c_SH_CLKHI  = 4'd9;
    localparam logic [3:0] c_SH_CLKLO  = 4'd10;
    localparam logic [3:0] c_DONE      = 4'd11;

    localparam logic [7:0] c_CHAR_0  = 8'h30;
    localparam logic [7:0] c_CHAR_1  = 8'h31;
    localparam logic [7:0] c_CHAR_NL = 8'h0A;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [c_RST_W-1:0] w_rst_cnt;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic [c_RUN_W-1:0] w_run_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt;
    logic [c_COL_W-1:0] r_col_cnt;
    logic [c_COL_W-1:0] w_col_cnt;

    logic               w_last_bit;
    logic               w_tx_start;
    logic [7:0]         w_tx_data;
    logic               w_scan_mode;

    assign w_last_bit = (r_bit_cnt == c_BIT_LAST);

    always_comb begin
        w_next    = r_state;
        w_rst_cnt = r_rst_cnt;
        w_run_cnt = r_run_cnt;
        w_bit_cnt = r_bit_cnt;
        w_col_cnt = r_col_cnt;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_next    = c_SOC_RST;
                    w_rst_cnt = '0;
                end
            end
            c_SOC_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_run_cnt = '0;
                    w_next    = (RUN_TICKS == 0) ? c_SETUP : c_RUN_HI;
                end else begin
                    w_rst_cnt = r_rst_cnt + 1'b1;
                end
            end
            c_RUN_HI: w_next = c_RUN_LO;
            c_RUN_LO: begin
                if (r_run_cnt == c_RUN_LAST) begin
                    w_next = c_SETUP;
                end else begin
                    w_run_cnt = r_run_cnt + 1'b1;
                    w_next    = c_RUN_HI;
                end
            end
            c_SETUP: begin
                w_bit_cnt = '0;
                w_col_cnt = '0;
                w_next    = c_SH_TX;
            end
            c_SH_TX: begin
                if (tx.tx_ready_i) w_next = c_SH_WAIT;
            end
            // A full line and the last bit share one newline.
            c_SH_WAIT: begin
                if (tx.tx_ready_i) begin
                    if ((r_col_cnt == c_COL_LAST) || w_last_bit) begin
                        w_col_cnt = '0;
                        w_next    = c_SH_NL;
                    end else begin
                        w_col_cnt = r_col_cnt + 1'b1;
                        w_next    = c_SH_CLKHI;
                    end
                end
            end
            c_SH_NL: begin
                if (tx.tx_ready_i) w_next = c_SH_NLWAIT;
            end
            c_SH_NLWAIT: begin
                if (tx.tx_ready_i) w_next = w_last_bit ? c_DONE : c_SH_CLKHI;
            end
            c_SH_CLKHI: w_next = c_SH_CLKLO;
            c_SH_CLKLO: begin
                w_bit_cnt = r_bit_cnt + 1'b1;
                w_next    = c_SH_TX;
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    assign w_scan_mode = (w_next == c_SETUP)     || (w_next == c_SH_TX)     ||
                         (w_next == c_SH_WAIT)   || (w_next == c_SH_NL)     ||
                         (w_next == c_SH_NLWAIT) || (w_next == c_SH_CLKHI)  ||
                         (w_next == c_SH_CLKLO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_rst_cnt    <= '0;
            r_run_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_col_cnt    <= '0;
            csoc_clk     <= 1'b0;
            csoc_rstn    <= 1'b0;
            csoc_test_se <= 1'b0;
            csoc_test_tm <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_rst_cnt    <= w_rst_cnt;
            r_run_cnt    <= w_run_cnt;
            r_bit_cnt    <= w_bit_cnt;
            r_col_cnt    <= w_col_cnt;
            csoc_clk     <= (w_next == c_RUN_HI) || (w_next == c_SH_CLKHI);
            csoc_rstn    <= (w_next != c_SOC_RST);
            csoc_test_se <= w_scan_mode;
            csoc_test_tm <= w_scan_mode;
            done_o       <= (w_next == c_DONE);
        end
    end

    // The scan bit is sampled in the strobe cycle, well after the last shift edge.
    always_comb begin
        w_tx_start = ((r_state == c_SH_TX) || (r_state == c_SH_NL)) && tx.tx_ready_i;
        w_tx_data  = 8'h00;
        if (w_tx_start) begin
            if (r_state == c_SH_NL) begin
                w_tx_data = c_CHAR_NL;
            end else begin
                w_tx_data = csoc_scan_i ? c_CHAR_1 : c_CHAR_0;
            end
        end
    end

    assign tx.tx_start_o = w_tx_start;
    assign tx.tx_data_o  = w_tx_data;
    assign busy_o        = (r_state != c_IDLE);
    assign csoc_scan_o   = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_scan_dump_sequencer.sv
// ============================================================================
// Module      : tb_scan_dump_sequencer
// Description : Self-checking bench for scan_dump_sequencer with a byte
//               scoreboard, a CSoC scan-chain model and a slow-UART model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_dump_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] start;
    logic [1:0] ready;
    logic [1:0] scan_in;
    wire  [1:0] busy, done, txs, cclk, crstn, se, tm, scan_out;
    wire  [7:0] txd0, txd1;

    int checks   = 0;
    int failures = 0;

    byte unsigned q0[$];
    byte unsigned q1[$];

    logic [7:0] bits [2];
    int fn_p[2], sc_p[2], bad_p[2], rlow[2], dcnt[2], nbytes[2], idx[2], slow_cnt[2];
    bit slow[2], prev_clk[2], strobe_seen[2], prev_rlow[2], se_after[2];

    scan_dump_sequencer_if if_a ();
    scan_dump_sequencer_if if_b ();

    assign if_a.tx_ready_i = ready[0];
    assign if_b.tx_ready_i = ready[1];
    assign txs[0] = if_a.tx_start_o;
    assign txs[1] = if_b.tx_start_o;
    assign txd0   = if_a.tx_data_o;
    assign txd1   = if_b.tx_data_o;

    scan_dump_sequencer #(.CHAIN_LEN(5), .RUN_TICKS(3), .COLS(4), .RST_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .tx(if_a), .csoc_clk(cclk[0]), .csoc_rstn(crstn[0]), .csoc_test_se(se[0]),
        .csoc_test_tm(tm[0]), .csoc_scan_i(scan_in[0]), .csoc_scan_o(scan_out[0])
    );

    scan_dump_sequencer #(.CHAIN_LEN(4), .RUN_TICKS(0), .COLS(4), .RST_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .tx(if_b), .csoc_clk(cclk[1]), .csoc_rstn(crstn[1]), .csoc_test_se(se[1]),
        .csoc_test_tm(tm[1]), .csoc_scan_i(scan_in[1]), .csoc_scan_o(scan_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-negedge observer: scan-chain model, pulse/cycle counters, scoreboard pop.
    task automatic mon(input int k);
        logic [7:0] d, e;
        d = (k == 0) ? txd0 : txd1;
        if (rst) begin
            idx[k] = 0; prev_clk[k] = 0; prev_rlow[k] = 0; strobe_seen[k] = 0;
        end else begin
            if (cclk[k] && !prev_clk[k]) begin
                if (se[k] && tm[k]) begin
                    sc_p[k]++;
                    if (idx[k] < 7) idx[k]++;
                end else if (!se[k] && !tm[k]) fn_p[k]++;
                else bad_p[k]++;
            end
            prev_clk[k] = cclk[k];
            if (prev_rlow[k] && crstn[k] && busy[k]) se_after[k] = se[k];
            prev_rlow[k] = !crstn[k] && busy[k];
            if (!crstn[k] && busy[k]) rlow[k]++;
            if (done[k]) dcnt[k]++;
            if (txs[k]) begin
                strobe_seen[k] = 1;
                nbytes[k]++;
                chk("strobe_while_ready", {31'd0, ready[k]}, 32'd1);
                e = 8'hFF;
                if (k == 0 && q0.size() > 0) e = q0.pop_front();
                if (k == 1 && q1.size() > 0) e = q1.pop_front();
                chk((k == 0) ? "tx_byte_a" : "tx_byte_b", {24'd0, d}, {24'd0, e});
            end
        end
        scan_in[k] = bits[k][idx[k][2:0]];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst) slow_cnt[k] = 0;
            else if (strobe_seen[k] && slow[k]) slow_cnt[k] = 10;
            else if (slow_cnt[k] > 0) slow_cnt[k]--;
            strobe_seen[k] = 0;
            ready[k] = (slow_cnt[k] == 0);
        end
        @(negedge clk);
        mon(0);
        mon(1);
    endtask

    task automatic launch(input int k);
        int n, col;
        n   = (k == 0) ? 5 : 4;
        col = 0;
        for (int i = 0; i < n; i++) begin
            byte unsigned c;
            c = bits[k][i] ? 8'h31 : 8'h30;
            if (k == 0) q0.push_back(c); else q1.push_back(c);
            col++;
            if (col == 4 || i == n - 1) begin
                if (k == 0) q0.push_back(8'h0A); else q1.push_back(8'h0A);
                col = 0;
            end
        end
        fn_p[k] = 0; sc_p[k] = 0; bad_p[k] = 0; rlow[k] = 0; dcnt[k] = 0;
        nbytes[k] = 0; idx[k] = 0; se_after[k] = 0;
        scan_in[k] = bits[k][0];
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while (busy[k] && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic check_run_a(input string tag);
        chk({tag, "_bytes"}, nbytes[0], 32'd7);
        chk({tag, "_queue_left"}, q0.size(), 32'd0);
        chk({tag, "_rstn_low"}, rlow[0], 32'd2);
        chk({tag, "_fn_pulses"}, fn_p[0], 32'd3);
        chk({tag, "_scan_pulses"}, sc_p[0], 32'd4);
        chk({tag, "_bad_pulses"}, bad_p[0], 32'd0);
        chk({tag, "_done"}, dcnt[0], 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy[0]}, 32'd0);
    endtask

    initial begin
        int n;
        bits[0] = 8'b0000_1101;
        bits[1] = 8'b0000_0110;
        for (int k = 0; k < 2; k++) begin
            slow[k] = 0; slow_cnt[k] = 0; strobe_seen[k] = 0; idx[k] = 0;
        end
        rst = 1'b1; start = 2'b00; ready = 2'b11; scan_in = 2'b00;

        // Reset values
        tick(); tick();
        chk("rst_busy", {30'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_tx_start", {30'd0, txs}, 32'd0);
        chk("rst_tx_data", {16'd0, txd1, txd0}, 32'd0);
        chk("rst_csoc_clk", {30'd0, cclk}, 32'd0);
        chk("rst_csoc_rstn", {30'd0, crstn}, 32'd0);
        chk("rst_se_tm", {28'd0, se, tm}, 32'd0);
        chk("rst_scan_o", {30'd0, scan_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_rstn", {30'd0, crstn}, 32'd3);
        chk("rel_busy", {30'd0, busy}, 32'd0);

        // Full dump with UART always ready
        launch(0);
        wait_idle(0, 200);
        check_run_a("full");

        // Slow UART
        slow[0] = 1;
        launch(0);
        wait_idle(0, 1000);
        check_run_a("slow");
        slow[0] = 0;
        tick(); tick(); tick();

        // Starts during shift and in the DONE cycle are ignored
        launch(0);
        n = 0;
        while (nbytes[0] < 2 && n < 200) begin tick(); n++; end
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 200) begin tick(); n++; end
        chk("ign_done_seen", {31'd0, done[0]}, 32'd1);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_run_a("ignored");

        // Reset in the middle of the shift
        launch(0);
        n = 0;
        while (nbytes[0] < 2 && n < 200) begin tick(); n++; end
        chk("mid_two_bytes", nbytes[0], 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_tx_start", {31'd0, txs[0]}, 32'd0);
        chk("mid_tx_data", {24'd0, txd0}, 32'd0);
        chk("mid_csoc", {28'd0, cclk[0], crstn[0], se[0], tm[0]}, 32'd0);
        chk("mid_done", {31'd0, done[0]}, 32'd0);
        q0.delete();
        tick();
        rst = 1'b0;
        tick();
        launch(0);
        wait_idle(0, 200);
        check_run_a("after_rst");

        // RUN_TICKS=0, CHAIN_LEN=4 instance
        launch(1);
        wait_idle(1, 200);
        chk("edge_bytes", nbytes[1], 32'd5);
        chk("edge_queue_left", q1.size(), 32'd0);
        chk("edge_fn_pulses", fn_p[1], 32'd0);
        chk("edge_scan_pulses", sc_p[1], 32'd3);
        chk("edge_setup_direct", {31'd0, se_after[1]}, 32'd1);
        chk("edge_rstn_low", rlow[1], 32'd2);
        chk("edge_done", dcnt[1], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
